// File: rtl/rx_crc_checker.sv
`timescale 1ns/1ps
// CRC-32 checker for the endpoint RX word stream: validates header+payload against the
// trailing CRC word, reports matches, mismatches and stalled packets, and counts errors.
module rx_crc_checker #(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 256,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flit_valid,
    input  logic [31:0]      flit_data,
    output logic             flit_ready,
    output logic             crc_valid,
    output logic [6:0]       metadata,
    output logic             crc_error,
    output logic             timeout_error,
    output logic [ERR_W-1:0] crc_err_count,
    output logic [ERR_W-1:0] timeout_count,
    output logic [1:0]       dbg_state      // 0 IDLE, 1 PAYLOAD, 2 CHECK, 3 REPORT
);
    // Handshake: a word moves on a rising edge only when flit_valid && flit_ready; while
    // flit_ready is low the upstream must hold flit_data stable and flit_valid is ignored.

    localparam int          LEN_W    = $clog2(MAX_LEN);
    localparam int          CNT_W    = LEN_W + 1;
    localparam int          WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [31:0] POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, REPORT} state_t;

    state_t            state, state_d;
    logic [31:0]       crc, crc_d;
    logic [CNT_W-1:0]  rem, rem_d;
    logic [WD_W-1:0]   wd, wd_d;
    logic [6:0]        meta_q, meta_d;
    logic              pass_d, fail_d, to_d;
    logic              xfer;

    // Non-reflected CRC-32 over one word, MSB first, unrolled into one cycle.
    function automatic logic [31:0] crc32_word(input logic [31:0] c_in, input logic [31:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ POLY;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    assign xfer      = flit_valid && flit_ready;
    assign dbg_state = state;

    always_comb begin
        state_d    = state;
        crc_d      = crc;
        rem_d      = rem;
        wd_d       = wd;
        meta_d     = meta_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        to_d       = 1'b0;
        flit_ready = (state != REPORT);
        case (state)
            IDLE: begin
                wd_d = '0;
                if (xfer) begin
                    crc_d   = crc32_word(CRC_INIT, flit_data);
                    meta_d  = flit_data[10:4];
                    rem_d   = {1'b0, flit_data[LEN_W-1:0]} + 1'b1;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD, CHECK: begin
                if (xfer) begin
                    wd_d = '0;
                    if (state == PAYLOAD) begin
                        crc_d = crc32_word(crc, flit_data);
                        rem_d = rem - 1'b1;
                        if (rem == CNT_W'(1)) state_d = CHECK;
                    end else begin
                        pass_d  = (flit_data == ~crc);
                        fail_d  = (flit_data != ~crc);
                        state_d = REPORT;
                    end
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    // Watchdog expiry: drop the partial packet; next word is a header.
                    to_d    = 1'b1;
                    wd_d    = '0;
                    crc_d   = CRC_INIT;
                    state_d = IDLE;
                end else begin
                    wd_d = wd + 1'b1;
                end
            end
            REPORT: begin
                crc_d   = CRC_INIT;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            crc           <= CRC_INIT;
            rem           <= '0;
            wd            <= '0;
            meta_q        <= '0;
            crc_valid     <= 1'b0;
            crc_error     <= 1'b0;
            timeout_error <= 1'b0;
            metadata      <= '0;
            crc_err_count <= '0;
            timeout_count <= '0;
        end else begin
            state         <= state_d;
            crc           <= crc_d;
            rem           <= rem_d;
            wd            <= wd_d;
            meta_q        <= meta_d;
            crc_valid     <= pass_d;
            crc_error     <= fail_d;
            timeout_error <= to_d;
            if (pass_d) metadata <= meta_q;
            if (fail_d && (crc_err_count != '1)) crc_err_count <= crc_err_count + 1'b1;
            if (to_d && (timeout_count != '1))   timeout_count <= timeout_count + 1'b1;
        end
    end

endmodule

// File: doc/rx_crc_checker.md
Name: rx_crc_checker

Overview:
Upstream neighbour of the endpoint requestor FIFO. Consumes the inbound packet word stream from the endpoint RX path, runs CRC-32 over the header and payload, and compares the result against the trailing CRC word. On a match it pulses crc_valid with the 7-bit header metadata, which drives the requestor FIFO's write port directly. It also reports CRC mismatches and stalled packets, and keeps saturating error counters.

Parameters:
MAX_LEN, 16, maximum payload words per packet; the length field is $clog2(MAX_LEN) bits wide.
TIMEOUT, 256, idle cycles tolerated mid-packet before the packet is aborted.
ERR_W, 8, width of each saturating error counter.

Ports:
clk  input  1  clock
n_rst  input  1  asynchronous active-low reset
flit_valid  input  1  inbound word valid
flit_data  input  32  inbound word
flit_ready  output  1  checker accepts a word this cycle when asserted with flit_valid
crc_valid  output  1  one-cycle pulse: packet CRC matched; connects to the FIFO write enable
metadata  output  7  header metadata, valid while crc_valid is high
crc_error  output  1  one-cycle pulse: CRC mismatch
timeout_error  output  1  one-cycle pulse: packet aborted by the watchdog
crc_err_count  output  ERR_W  saturating count of CRC mismatches
timeout_count  output  ERR_W  saturating count of timeouts

Behaviour:
- Reset (async, n_rst=0): state IDLE; CRC register = 32'hFFFFFFFF; all pulse outputs 0; metadata 0; both counters 0; flit_ready 1.
- Transfer occurs on a rising edge when flit_valid && flit_ready.
- Packet format:
  - Word 0 is the header: [3:0] = payload length minus 1, so 1..MAX_LEN payload words; [10:4] = metadata; [31:11] are covered by the CRC and otherwise ignored.
  - Header is followed by len payload words, then one CRC word.
- CRC-32: polynomial 32'h04C11DB7, init 32'hFFFFFFFF, not reflected. Each word is processed MSB first, 32 bits per cycle, combinationally. The expected value is the bitwise NOT of the register after the last payload word.
- State machine:
  - IDLE: on transfer, latch metadata and length, set CRC = crc32(FFFFFFFF, word), clear the remaining-word counter to len, go to PAYLOAD.
  - PAYLOAD: on each transfer, update the CRC and decrement the remaining count. When the count reaches 0 after the transfer, go to CHECK.
  - CHECK: on transfer, compare flit_data with ~crc and go to REPORT.
  - REPORT: flit_ready=0 for exactly this one cycle. crc_valid=1 with metadata if the compare matched, else crc_error=1. Next state is IDLE with CRC reinitialised.
- Latency: result pulse is 1 cycle after the CRC word is accepted. Minimum packet period is len+3 cycles.
- Pulses and metadata are registered outputs. metadata holds its last value between pulses. crc_valid and crc_error are never high together.
- Watchdog:
  - In PAYLOAD or CHECK, a counter increments on every cycle without a transfer and resets on any transfer.
  - When it reaches TIMEOUT, assert timeout_error for 1 cycle and go to IDLE. Partial data is discarded and no crc_valid is issued.
  - The word following a timeout is treated as a new header.
- Counters:
  - crc_err_count increments on each crc_error and saturates at all-ones.
  - timeout_count increments on each timeout_error and saturates at all-ones.
  - Counters are cleared only by reset.
- flit_valid is ignored while flit_ready=0; upstream must hold the word.
- Reset mid-packet: state returns to IDLE immediately and no pulse is emitted.

Test Plan:
- Header len field=0 (1 payload word), metadata=7'h2A, correct CRC word -> crc_valid=1 for one cycle with metadata=7'h2A, exactly 1 cycle after the CRC word; flit_ready=0 that cycle.
- 16-payload packet (len field=4'hF) with payload bit 0 of word 7 flipped -> crc_error=1, crc_valid=0, crc_err_count 0->1.
- Back-to-back packets with flit_valid held high -> each emits one crc_valid; the word presented during REPORT is not consumed until the next cycle.
- Header plus 2 of 4 payload words, then flit_valid=0 for 256 cycles -> timeout_error on the cycle the counter hits 256, timeout_count=1; the next well-formed packet passes.
- 260 corrupted packets -> crc_err_count saturates at 8'hFF with no wrap.
- Assert n_rst=0 during PAYLOAD -> all outputs at reset values; the next packet passes normally.
